multi_lane_stream_adder: RTL and testbench

- N-input generalisation of the byte stream adder.
- Joins NUM_IN valid/ready input lanes and emits one sum beat per joined input beat.
- Output passes through a 2-entry buffer, so a one-cycle sum_ready drop does not stall inputs immediately.
- Frames beats into streams of STREAM_LENGTH with a last marker.
- Optional saturating mode clamps sums to DATA_WIDTH.
- Sits between parallel byte-stream producers and a single downstream consumer.

---
 rtl/multi_lane_stream_adder.sv | 126 ++++++++++++
 tb/tb_multi_lane_stream_adder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_stream_adder.sv
// Joins NUM_IN valid/ready byte lanes, sums each joined beat and frames it into streams through a 2-entry output FIFO.
// Define STREAM_ADDER_PERF_EN to add a saturating 16-bit stall_count output.
module multi_lane_stream_adder #(
  parameter int  DATA_WIDTH    = 8,
  parameter int  NUM_IN        = 2,
  parameter int  STREAM_LENGTH = 16,
  parameter int  SATURATE      = 0,
  localparam int SUM_WIDTH     = DATA_WIDTH + $clog2(NUM_IN)
) (
  input  logic                         clock,
  input  logic                         reset,
`ifdef STREAM_ADDER_PERF_EN
  output logic [15:0]                  stall_count,
`endif
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [SUM_WIDTH-1:0]         sum_data,
  output logic                         sum_last,
  output logic                         sum_valid,
  input  logic                         sum_ready
);

  localparam int CNT_W = (STREAM_LENGTH > 1) ? $clog2(STREAM_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(STREAM_LENGTH - 1);
  localparam logic [SUM_WIDTH-1:0] SAT_MAX =
    {{(SUM_WIDTH - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic [1:0]           occ_q, occ_d;
  logic [SUM_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                 last0_q, last0_d, last1_q, last1_d;
  logic [CNT_W-1:0]     beat_q, beat_d;

  logic [SUM_WIDTH-1:0] sum_full, sum_beat;
  logic                 space, fire, pop, beat_last;

  always_comb begin
    sum_full = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sum_full = sum_full + SUM_WIDTH'(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
    sum_beat = sum_full;
    if ((SATURATE != 0) && (sum_full > SAT_MAX)) begin
      sum_beat = SAT_MAX;
    end
  end

  // Ready depends only on registered occupancy, never on sum_ready.
  assign space     = (occ_q != 2'd2);
  assign fire      = space && (&in_valid);
  assign pop       = (occ_q != 2'd0) && sum_ready;
  assign beat_last = (beat_q == LAST_BEAT);

  assign in_ready  = {NUM_IN{fire}};
  assign sum_valid = (occ_q != 2'd0);
  assign sum_data  = data0_q;
  assign sum_last  = last0_q;

  always_comb begin
    occ_d   = occ_q;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    beat_d  = beat_q;
    if (fire) begin
      beat_d = beat_last ? '0 : beat_q + CNT_W'(1);
    end
    // Push with pop only happens at occupancy 1, so the new beat becomes the head.
    case ({fire, pop})
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = sum_beat;
          last0_d = beat_last;
        end else begin
          data1_d = sum_beat;
          last1_d = beat_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        data0_d = sum_beat;
        last0_d = beat_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q   <= 2'd0;
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      beat_q  <= beat_d;
    end
  end

`ifdef STREAM_ADDER_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= 16'd0;
    end else if (sum_valid && !sum_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_multi_lane_stream_adder.sv
// Self-checking bench for multi_lane_stream_adder: queue-based reference model plus directed literal checks.
// Honours STREAM_ADDER_PERF_EN when defined at compile time.
module tb_multi_lane_stream_adder;

  logic        clock;
  logic        reset;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [8:0]  sum_data;
  logic        sum_last;
  logic        sum_valid;
  logic        sum_ready;

  logic [31:0] in4_data;
  logic [3:0]  in4_valid;
  logic        ready4;
  logic [3:0]  in4_ready_a, in4_ready_b;
  logic [9:0]  s4a_data, s4b_data;
  logic        s4a_last, s4b_last, s4a_valid, s4b_valid;

`ifdef STREAM_ADDER_PERF_EN
  logic [15:0] stall_count, stall4a, stall4b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  multi_lane_stream_adder #(.DATA_WIDTH(8), .NUM_IN(2), .STREAM_LENGTH(16), .SATURATE(0)) dut (
    .clock(clock), .reset(reset),
`ifdef STREAM_ADDER_PERF_EN
    .stall_count(stall_count),
`endif
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sum_data(sum_data), .sum_last(sum_last), .sum_valid(sum_valid), .sum_ready(sum_ready)
  );

  multi_lane_stream_adder #(.DATA_WIDTH(8), .NUM_IN(4), .STREAM_LENGTH(16), .SATURATE(0)) dut4 (
    .clock(clock), .reset(reset),
`ifdef STREAM_ADDER_PERF_EN
    .stall_count(stall4a),
`endif
    .in_data(in4_data), .in_valid(in4_valid), .in_ready(in4_ready_a),
    .sum_data(s4a_data), .sum_last(s4a_last), .sum_valid(s4a_valid), .sum_ready(ready4)
  );

  multi_lane_stream_adder #(.DATA_WIDTH(8), .NUM_IN(4), .STREAM_LENGTH(16), .SATURATE(1)) dut4s (
    .clock(clock), .reset(reset),
`ifdef STREAM_ADDER_PERF_EN
    .stall_count(stall4b),
`endif
    .in_data(in4_data), .in_valid(in4_valid), .in_ready(in4_ready_b),
    .sum_data(s4b_data), .sum_last(s4b_last), .sum_valid(s4b_valid), .sum_ready(ready4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output buffer is a queue of {sum, last}; framing is a beat index mod 16.
  typedef struct {
    logic [8:0] d;
    logic       l;
  } beat_t;

  beat_t mq[$];
  int    m_beat  = 0;
  int    m_stall = 0;
  bit    m_pop, m_push;
  beat_t m_new;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_beat  = 0;
      m_stall = 0;
    end else begin
      m_pop  = (mq.size() != 0) && sum_ready;
      m_push = (mq.size() < 2) && (in_valid == 2'b11);
      if ((mq.size() != 0) && !sum_ready && (m_stall < 65535)) m_stall++;
      if (m_push) begin
        m_new.d = 9'(in_data[7:0]) + 9'(in_data[15:8]);
        m_new.l = (m_beat == 15);
        m_beat  = (m_beat + 1) % 16;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_new);
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_in_ready", in_ready, ((mq.size() < 2) && (in_valid == 2'b11)) ? 2'b11 : 2'b00);
      check("m_sum_valid", sum_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("m_sum_data", sum_data, mq[0].d);
        check("m_sum_last", sum_last, mq[0].l);
      end
`ifdef STREAM_ADDER_PERF_EN
      check("m_stall_count", stall_count, m_stall);
`endif
    end
  end

  task automatic drive(input int a, input int b);
    in_data  = {8'(b), 8'(a)};
    in_valid = 2'b11;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset    = 1'b1;
    in_valid = 2'b00;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Lanes a=j%16, b=15-j%16 fed back to back with sum_ready=1: every sum is 15, last on beat 15.
  task automatic run_stream(input int n);
    @(posedge clock); #1;
    sum_ready = 1'b1;
    drive(0, 15);
    for (int j = 0; j < n; j++) begin
      @(posedge clock); #1;
      if (j + 1 < n) drive((j + 1) % 16, 15 - ((j + 1) % 16));
      else in_valid = 2'b00;
      @(negedge clock);
      check("stream_valid", sum_valid, 1);
      check("stream_sum", sum_data, 9'd15);
      check("stream_last", sum_last, (j % 16) == 15);
    end
  endtask

  int acc;
  int s4;
  int e_sat;
  logic [31:0] pat;

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    sum_ready = 1'b0;
    in4_data  = '0;
    in4_valid = '0;
    ready4    = 1'b1;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1;
    @(negedge clock);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_sum_data", sum_data, 0);
    check("rst_sum_last", sum_last, 0);
    check("rst_in_ready", in_ready, 0);

    run_stream(17);

    // Backpressure: only two beats fit, data held stable at AA+55.
    @(posedge clock); #1;
    sum_ready = 1'b0;
    in_data   = {8'h55, 8'hAA};
    in_valid  = 2'b11;
    acc = 0;
    repeat (5) begin
      @(negedge clock);
      if (in_ready == 2'b11) acc++;
      if (sum_valid) check("bp_hold_data", sum_data, 9'h0FF);
      @(posedge clock); #1;
    end
    check("bp_accepted", acc, 2);
    check("bp_full_ready", in_ready, 2'b00);
    sum_ready = 1'b1;
    @(negedge clock);
    check("bp_no_comb_ready", in_ready, 2'b00);
    @(posedge clock); #1;
    @(negedge clock);
    check("bp_reassert", in_ready, 2'b11);
    @(posedge clock); #1;
    in_valid = 2'b00;
    repeat (4) @(posedge clock);
    #1;

    // Join skew: lane1 idle means nothing is consumed.
    in_data  = {8'h10, 8'h21};
    in_valid = 2'b01;
    repeat (3) begin
      @(negedge clock);
      check("skew_ready", in_ready, 2'b00);
      check("skew_no_out", sum_valid, 0);
      @(posedge clock); #1;
    end
    in_valid = 2'b11;
    @(posedge clock); #1;
    in_valid = 2'b00;
    @(negedge clock);
    check("skew_one_valid", sum_valid, 1);
    check("skew_sum", sum_data, 9'h031);
    @(posedge clock); #1;
    @(negedge clock);
    check("skew_single_beat", sum_valid, 0);

    // Reset mid-stream with beats 4 and 5 buffered.
    do_reset();
    sum_ready = 1'b1;
    drive(3, 4);
    repeat (4) @(posedge clock);
    #1 in_valid = 2'b00;
    @(posedge clock); #1;
    sum_ready = 1'b0;
    drive(9, 1);
    repeat (2) @(posedge clock);
    #1;
    in_valid = 2'b00;
    @(negedge clock);
    check("mid_two_buffered", sum_valid, 1);
    check("mid_full_ready", in_ready, 2'b00);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_reset_valid", sum_valid, 0);
    run_stream(16);

    // Randomised traffic against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      reset     = ($urandom_range(0, 399) == 0);
      in_data   = 16'($urandom);
      in_valid  = {1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0)};
      sum_ready = 1'($urandom_range(0, 3) != 0);
    end
    @(posedge clock); #1;
    reset    = 1'b0;
    in_valid = 2'b00;

    // Four-lane full-precision and saturating instances.
    for (int k = 0; k < 24; k++) begin
      pat = (k == 0) ? 32'hFFFF_FFFF : $urandom;
      if (k == 1) pat = 32'h0102_0304;
      s4 = int'(pat[7:0]) + int'(pat[15:8]) + int'(pat[23:16]) + int'(pat[31:24]);
      e_sat = (s4 > 255) ? 255 : s4;
      @(posedge clock); #1;
      in4_data  = pat;
      in4_valid = 4'hF;
      @(posedge clock); #1;
      in4_valid = 4'h0;
      @(negedge clock);
      check("lane4_valid", s4a_valid, 1);
      check("lane4_sum", s4a_data, s4);
      check("lane4_sat_sum", s4b_data, e_sat);
      if (k == 0) begin
        check("lane4_ff_full", s4a_data, 10'h3FC);
        check("lane4_ff_sat", s4b_data, 10'h0FF);
      end
      if (k == 1) check("lane4_small_sat", s4b_data, 10'h00A);
    end

`ifdef STREAM_ADDER_PERF_EN
    do_reset();
    sum_ready = 1'b0;
    drive(1, 2);
    @(posedge clock); #1;
    in_valid = 2'b00;
    repeat (7) @(posedge clock);
    #1;
    check("stall_count_7", stall_count, 16'd7);
    sum_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
`endif

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
